memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/llsc_link.sv | 32 +++
 rtl/memory_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and the memory-stage state encoding.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Word index of a byte address; the LL/SC link tracks whole words.
    function automatic logic [29:0] word_index(input word_t byte_addr);
        return byte_addr[31:2];
    endfunction
endpackage

// File: rtl/llsc_link.sv
// Load-linked reservation register: one word address plus a valid bit.
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        set,
    input  word_t       addr,
    input  logic        clr,
    input  logic        snoop,
    output logic        valid,
    output logic [29:0] link_addr
);
    logic        valid_reg;
    logic [29:0] addr_reg;

    // A new LL reservation beats any clear landing on the same edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
        end else if (set) begin
            valid_reg <= 1'b1;
            addr_reg  <= word_index(addr);
        end else if (clr || snoop) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid     = valid_reg;
    assign link_addr = addr_reg;
endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: drives the data cache, stalls until dhit, handles LL/SC.
module memory_stage
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ex_dREN,
    input  logic  ex_dWEN,
    input  logic  ex_datomic,
    input  word_t ex_addr,
    input  word_t ex_store,
    input  logic  wb_en,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  ccinv,
    input  word_t ccsnoopaddr,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output logic  mem_stall,
    output word_t mem_rdata
);
    mem_state_t  state_reg;
    word_t       rdata_q;
    logic        link_valid;
    logic [29:0] link_addr;

    logic  is_sc, is_ll, is_plain_store;
    logic  snoop_hit, sc_fail, op_valid, active, done_now;
    logic  link_set, link_clr;
    word_t result;

    assign is_sc          = ex_datomic & ex_dWEN;
    assign is_ll          = ex_datomic & ex_dREN & ~ex_dWEN;
    assign is_plain_store = ex_dWEN & ~ex_datomic;

    assign snoop_hit = ccinv & (word_index(ccsnoopaddr) == link_addr);
    assign sc_fail   = is_sc & (~link_valid | (link_addr != word_index(ex_addr)) | snoop_hit);
    assign op_valid  = (ex_dREN | ex_dWEN) & ~sc_fail;
    assign active    = op_valid & (state_reg != DONE);
    assign done_now  = active & dhit;
    assign result    = is_sc ? 32'd1 : dmemload;

    // A failed SC never reaches the cache but still retires its reservation.
    assign link_set = done_now & is_ll;
    assign link_clr = (sc_fail & (state_reg != DONE))
                    | (done_now & is_sc)
                    | (done_now & is_plain_store & (word_index(ex_addr) == link_addr));

    llsc_link u_link (
        .CLK       (CLK),
        .nRST      (nRST),
        .set       (link_set),
        .addr      (ex_addr),
        .clr       (link_clr),
        .snoop     (snoop_hit),
        .valid     (link_valid),
        .link_addr (link_addr)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            rdata_q   <= '0;
        end else begin
            case (state_reg)
                IDLE, BUSY: begin
                    if (!op_valid) begin
                        state_reg <= IDLE;
                    end else if (dhit) begin
                        rdata_q   <= result;
                        state_reg <= wb_en ? IDLE : DONE;
                    end else begin
                        state_reg <= BUSY;
                    end
                end
                DONE: begin
                    if (wb_en) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is held so a pending request drops at once.
    assign dmemWEN   = nRST & active & ex_dWEN;
    assign dmemREN   = nRST & active & ex_dREN & ~ex_dWEN;
    assign dmemaddr  = (nRST & active) ? ex_addr  : '0;
    assign dmemstore = (nRST & active) ? ex_store : '0;
    assign mem_stall = nRST & active & ~dhit;

    always_comb begin
        mem_rdata = '0;
        if (nRST) begin
            if (state_reg == DONE) mem_rdata = rdata_q;
            else if (done_now)     mem_rdata = result;
        end
    end
endmodule
